// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller.
// Optional illegal-opcode trap is enabled with RISCV_MC_ILLEGAL_TRAP_EN (see riscv_mc_controller).
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    // Immediate format depends only on the opcode, never on the state.
    function automatic logic [2:0] imm_decode(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_ctrl.sv
// ALU control decoder: maps the FSM's ALU op class plus funct fields to a 3-bit ALU code.
module mc_alu_ctrl
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can encode sub; addi with imm[10] set stays add.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I main controller with memory req/ready handshake and timeout.
// Define RISCV_MC_ILLEGAL_TRAP_EN to add the `illegal` output and a sticky ERR state.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [2:0] alu_control,
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       bus_err
);

    // A zero timeout still needs a 1-bit counter to keep the logic legal.
    localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          state_q, state_n;
    logic [TO_W-1:0] to_cnt;
    alu_op_t         alu_op;
    logic [2:0]      alu_ctrl_raw;
    logic            mem_state;
    logic            to_hit;

    mc_alu_ctrl u_alu_ctrl (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctrl_raw)
    );

    assign alu_control = rst_n ? alu_ctrl_raw : ALU_ADD;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign to_hit    = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (to_cnt == TO_LIMIT);

    // NOTE: reset is sampled on the clock edge only; sequential state uses non-blocking
    // assignments so every register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            to_cnt  <= '0;
        end else begin
            state_q <= state_n;
            if ((state_n != state_q) || to_hit)
                to_cnt <= '0;
            else if (mem_state && !mem_ready)
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // NOTE: every output and state_n gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_n    = state_q;
        alu_op     = ALUOP_ADD;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        bus_err    = 1'b0;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif

        if (rst_n) begin
            if (state_q != S_ERR)
                imm_src = imm_decode(op);

            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_n  = S_DECODE;
                    end else if (to_hit) begin
                        bus_err = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (op)
                        OP_LW, OP_SW: state_n = S_MEMADR;
                        OP_R:         state_n = S_EXECR;
                        OP_I:         state_n = S_EXECI;
                        OP_BEQ:       state_n = S_BEQ;
                        OP_JAL:       state_n = S_JAL;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
                        default:      state_n = S_ERR;
`else
                        default:      state_n = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    state_n   = op[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        state_n = S_MEMWB;
                    end else if (to_hit) begin
                        bus_err = 1'b1;
                        state_n = S_FETCH;
                    end
                end
                S_MEMWB: begin
                    result_src = RES_RDATA;
                    reg_write  = 1'b1;
                    state_n    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) begin
                        state_n = S_FETCH;
                    end else if (to_hit) begin
                        bus_err = 1'b1;
                        state_n = S_FETCH;
                    end
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_FUNCT;
                    state_n   = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                    state_n   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_n   = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_SUB;
                    pc_write  = zero;
                    state_n   = S_FETCH;
                end
                S_JAL: begin
                    // Target is already in ALUOut; ALU computes oldPC+4 for the link write.
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                    state_n   = S_ALUWB;
                end
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
                S_ERR: begin
                    illegal = 1'b1;
                end
`endif
                default: state_n = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed cycle-by-cycle trace bench for riscv_mc_controller (MEM_TIMEOUT=4).
module tb_riscv_mc_controller;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] alu_control;
        logic       bus_err;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, bus_err;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    riscv_mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .bus_err     (bus_err)
    );

    function automatic outs_t o(input logic mreq, mwr, adr, irw, pcw, rgw,
                                input logic [1:0] rs, sa, sb,
                                input logic [2:0] imm, alu, input logic berr);
        outs_t r;
        r = '{mreq, mwr, adr, irw, pcw, rgw, rs, sa, sb, imm, alu, berr};
        return r;
    endfunction

    function automatic outs_t actual();
        outs_t r;
        r = '{mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              result_src, alu_src_a, alu_src_b, imm_src, alu_control, bus_err};
        return r;
    endfunction

    task automatic add(input string name, input logic rst, input logic [6:0] opc,
                       input logic [2:0] f3, input logic f7, input logic z, input logic rdy,
                       input outs_t exp);
        vec_t v;
        v.name = name; v.rst = rst; v.op = opc; v.f3 = f3; v.f7 = f7;
        v.z = z; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive inputs just after the active edge, then let outputs settle until the falling edge.
    task automatic step(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic z, input logic rdy);
        @(posedge clk);
        #1;
        rst_n = rst; op = opc; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        // Common expected shapes written out per row.
        add("reset",       0, R, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        // add x3,x1,x2
        add("add_fetch",   1, R, 3'd0, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("add_decode",  1, R, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("add_execr",   1, R, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,3'd0,0));
        add("add_aluwb",   1, R, 3'd0, 0, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        // sub
        add("sub_fetch",   1, R, 3'd0, 1, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("sub_decode",  1, R, 3'd0, 1, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("sub_execr",   1, R, 3'd0, 1, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,3'd1,0));
        add("sub_aluwb",   1, R, 3'd0, 1, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        // addi with imm bit 10 set: stays add
        add("addi_fetch",  1, I, 3'd0, 1, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("addi_decode", 1, I, 3'd0, 1, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("addi_execi",  1, I, 3'd0, 1, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,3'd0,0));
        add("addi_aluwb",  1, I, 3'd0, 1, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        // or
        add("or_fetch",    1, R, 3'd6, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("or_decode",   1, R, 3'd6, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("or_execr",    1, R, 3'd6, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,3'd3,0));
        add("or_aluwb",    1, R, 3'd6, 0, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        // slti, then andi
        add("slti_fetch",  1, I, 3'd2, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("slti_decode", 1, I, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("slti_execi",  1, I, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,3'd5,0));
        add("slti_aluwb",  1, I, 3'd2, 0, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        add("andi_fetch",  1, I, 3'd7, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("andi_decode", 1, I, 3'd7, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("andi_execi",  1, I, 3'd7, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,3'd2,0));
        add("andi_aluwb",  1, I, 3'd7, 0, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        // lw with three wait states in MEMREAD: 8 cycles
        add("lw_fetch",    1, LW, 3'd2, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("lw_decode",   1, LW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("lw_memadr",   1, LW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,3'd0,0));
        add("lw_wait1",    1, LW, 3'd2, 0, 0, 0, o(1,0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        add("lw_wait2",    1, LW, 3'd2, 0, 0, 0, o(1,0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        add("lw_wait3",    1, LW, 3'd2, 0, 0, 0, o(1,0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        add("lw_memread",  1, LW, 3'd2, 0, 0, 1, o(1,0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        add("lw_memwb",    1, LW, 3'd2, 0, 0, 1, o(0,0,0,0,0,1,2'd1,2'd0,2'd0,3'd0,3'd0,0));
        // sw
        add("sw_fetch",    1, SW, 3'd2, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd1,3'd0,0));
        add("sw_decode",   1, SW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd1,3'd0,0));
        add("sw_memadr",   1, SW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,3'd1,3'd0,0));
        add("sw_memwrite", 1, SW, 3'd2, 0, 0, 1, o(1,1,1,0,0,0,2'd0,2'd0,2'd0,3'd1,3'd0,0));
        // beq taken / not taken
        add("beq1_fetch",  1, BQ, 3'd0, 1, 1, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd2,3'd0,0));
        add("beq1_decode", 1, BQ, 3'd0, 1, 1, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd2,3'd0,0));
        add("beq1_beq",    1, BQ, 3'd0, 1, 1, 1, o(0,0,0,0,1,0,2'd0,2'd2,2'd0,3'd2,3'd1,0));
        add("beq0_fetch",  1, BQ, 3'd0, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd2,3'd0,0));
        add("beq0_decode", 1, BQ, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd2,3'd0,0));
        add("beq0_beq",    1, BQ, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd0,3'd2,3'd1,0));
        // jal
        add("jal_fetch",   1, JL, 3'd0, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd3,3'd0,0));
        add("jal_decode",  1, JL, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd3,3'd0,0));
        add("jal_jal",     1, JL, 3'd0, 0, 0, 1, o(0,0,0,0,1,0,2'd0,2'd1,2'd2,3'd3,3'd0,0));
        add("jal_aluwb",   1, JL, 3'd0, 0, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd3,3'd0,0));
        // FETCH timeout twice, then ready arrives exactly at the limit
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++)
                add("to_wait", 1, R, 3'd0, 0, 0, 0, o(1,0,0,0,0,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
            add("to_buserr",   1, R, 3'd0, 0, 0, 0, o(1,0,0,0,0,0,2'd2,2'd0,2'd2,3'd0,3'd0,1));
        end
        for (int j = 0; j < 4; j++)
            add("to_wait3",    1, R, 3'd0, 0, 0, 0, o(1,0,0,0,0,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("to_limit_rdy",    1, R, 3'd0, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0));
        add("to_decode",       1, R, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0));
        add("to_execr",        1, R, 3'd0, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,3'd0,0));
        add("to_aluwb",        1, R, 3'd0, 0, 0, 1, o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        // reset during MEMWRITE aborts the store
        add("rsw_fetch",   1, SW, 3'd2, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd1,3'd0,0));
        add("rsw_decode",  1, SW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd1,3'd0,0));
        add("rsw_memadr",  1, SW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,3'd1,3'd0,0));
        add("rsw_wait",    1, SW, 3'd2, 0, 0, 0, o(1,1,1,0,0,0,2'd0,2'd0,2'd0,3'd1,3'd0,0));
        add("rsw_reset",   0, SW, 3'd2, 0, 1, 1, o(0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
        add("rsw_refetch", 1, SW, 3'd2, 0, 0, 1, o(1,0,0,1,1,0,2'd2,2'd0,2'd2,3'd1,3'd0,0));
        add("rsw_decode2", 1, SW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,3'd1,3'd0,0));
        add("rsw_memadr2", 1, SW, 3'd2, 0, 0, 1, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,3'd1,3'd0,0));
        add("rsw_write",   1, SW, 3'd2, 0, 0, 1, o(1,1,1,0,0,0,2'd0,2'd0,2'd0,3'd1,3'd0,0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].rdy);
            check($sformatf("%s[%0d]", tbl[i].name, i), 32'(actual()), 32'(tbl[i].exp));
        end

        // Unlisted opcode
        step(1, BAD, 3'd0, 0, 0, 1);
        check("bad_fetch_ir_write", 32'(ir_write), 32'd1);
        step(1, BAD, 3'd0, 0, 0, 1);
        check("bad_decode_srca", 32'(alu_src_a), 32'd1);
        check("bad_decode_mem_req", 32'(mem_req), 32'd0);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        for (int j = 0; j < 3; j++) begin
            step(1, BAD, 3'd0, 0, 0, 1);
            check("err_illegal", 32'(illegal), 32'd1);
            check("err_outs", 32'(actual()), 32'd0);
        end
        step(0, BAD, 3'd0, 0, 0, 1);
        check("err_reset_illegal", 32'(illegal), 32'd0);
        step(1, R, 3'd0, 0, 0, 1);
        check("err_refetch_mem_req", 32'(mem_req), 32'd1);
        check("err_refetch_illegal", 32'(illegal), 32'd0);
`else
        step(1, R, 3'd0, 0, 0, 1);
        check("bad_nop_refetch_mem_req", 32'(mem_req), 32'd1);
        check("bad_nop_refetch_ir_write", 32'(ir_write), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
